// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ==========================================================================
// Module : uart_rx
// 8N1 serial receiver with a receive FIFO, data/status CSRs and a level IRQ.
// Rev    : 1.0
// ==========================================================================
module uart_rx #(
    parameter int          BIT_CYCLES  = 868,
    parameter int          DEPTH       = 8,
    parameter logic [11:0] DATA_ADDR   = 12'h051,
    parameter logic [11:0] STATUS_ADDR = 12'h052
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_pin,
    input  logic        csr_enable,
    input  logic [11:0] csr_addr,
    input  logic [2:0]  csr_op,
    input  logic [4:0]  rs1_zimm,
    input  logic [31:0] rs1_data,
    output logic [31:0] csr_data_out,
    output logic        interrupt
);
    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = $clog2(BIT_CYCLES);
    localparam logic [c_cw-1:0] c_full_last = c_cw'(BIT_CYCLES - 1);
    localparam logic [c_cw-1:0] c_half_last = c_cw'(BIT_CYCLES / 2 - 1);
    localparam logic [c_aw:0]   c_depth     = (c_aw + 1)'(DEPTH);

    localparam logic [2:0] c_op_rw  = 3'b001;
    localparam logic [2:0] c_op_rc  = 3'b011;
    localparam logic [2:0] c_op_rwi = 3'b101;
    localparam logic [2:0] c_op_rci = 3'b111;

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_start = 3'd1;
    localparam logic [2:0] c_data  = 3'd2;
    localparam logic [2:0] c_stop  = 3'd3;
    localparam logic [2:0] c_brk   = 3'd4;

    logic            rx_meta_q, rx_s_q;
    logic [2:0]      state_q, state_d;
    logic [c_cw-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [c_aw-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [c_aw:0]   count_q, count_d;
    logic            framing_err_q, framing_err_d;
    logic            overrun_q, overrun_d;
    logic            interrupt_q, interrupt_d;
    logic [7:0]      mem_q [DEPTH];

    logic w_half_done, w_bit_done, w_push_req, w_fe_set;
    logic w_empty, w_full, w_pop, w_wr, w_ovr_set;
    logic [1:0] w_clr;
    logic [7:0] w_head;
    logic w_unused;

    assign w_unused    = ^{rs1_data[31:2], rs1_zimm[4:2]};
    assign w_half_done = (cnt_q == c_half_last);
    assign w_bit_done  = (cnt_q == c_full_last);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= c_idle;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_idle:  if (!rx_s_q) state_d = c_start;
            c_start: if (w_half_done) state_d = rx_s_q ? c_idle : c_data;
            c_data:  if (w_bit_done && bit_idx_q == 3'd7) state_d = c_stop;
            c_stop:  if (w_bit_done) state_d = rx_s_q ? c_idle : c_brk;
            c_brk:   if (rx_s_q) state_d = c_idle;
            default: state_d = c_idle;
        endcase
    end

    // Per-state outputs: bit timing, shift register and frame completion
    always_comb begin
        cnt_d      = cnt_q + c_cw'(1);
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        w_push_req = 1'b0;
        w_fe_set   = 1'b0;
        case (state_q)
            c_start: begin
                if (w_half_done) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                end
            end
            c_data: begin
                if (w_bit_done) begin
                    cnt_d              = '0;
                    shift_d[bit_idx_q] = rx_s_q;
                    bit_idx_d          = bit_idx_q + 3'd1;
                end
            end
            c_stop: begin
                if (w_bit_done) begin
                    cnt_d      = '0;
                    w_push_req = rx_s_q;
                    w_fe_set   = !rx_s_q;
                end
            end
            default: begin
                cnt_d     = '0;
                bit_idx_d = 3'd0;
            end
        endcase
    end

    // FIFO bookkeeping; a pop in the push cycle frees the slot even when full
    always_comb begin
        w_empty   = (count_q == '0);
        w_full    = (count_q == c_depth);
        w_pop     = csr_enable && (csr_addr == DATA_ADDR) && !w_empty;
        w_wr      = w_push_req && (!w_full || w_pop);
        w_ovr_set = w_push_req && w_full && !w_pop;
        rd_ptr_d  = w_pop ? rd_ptr_q + c_aw'(1) : rd_ptr_q;
        wr_ptr_d  = w_wr  ? wr_ptr_q + c_aw'(1) : wr_ptr_q;
        count_d   = count_q;
        if (w_wr && !w_pop)      count_d = count_q + (c_aw + 1)'(1);
        else if (!w_wr && w_pop) count_d = count_q - (c_aw + 1)'(1);

        w_clr = 2'b00;
        if (csr_enable && csr_addr == STATUS_ADDR) begin
            case (csr_op)
                c_op_rw, c_op_rc:   w_clr = rs1_data[1:0];
                c_op_rwi, c_op_rci: w_clr = rs1_zimm[1:0];
                default:            w_clr = 2'b00;
            endcase
        end
        framing_err_d = (framing_err_q && !w_clr[0]) || w_fe_set;
        overrun_d     = (overrun_q && !w_clr[1]) || w_ovr_set;
        interrupt_d   = (count_d != '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q     <= 1'b1;
            rx_s_q        <= 1'b1;
            cnt_q         <= '0;
            bit_idx_q     <= 3'd0;
            shift_q       <= 8'h00;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            framing_err_q <= 1'b0;
            overrun_q     <= 1'b0;
            interrupt_q   <= 1'b0;
        end else begin
            rx_meta_q     <= rx_pin;
            rx_s_q        <= rx_meta_q;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            framing_err_q <= framing_err_d;
            overrun_q     <= overrun_d;
            interrupt_q   <= interrupt_d;
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (w_wr) mem_q[wr_ptr_q] <= shift_q;
    end

    always_comb begin
        w_head       = w_empty ? 8'h00 : mem_q[rd_ptr_q];
        csr_data_out = 32'h0000_0000;
        if (csr_addr == DATA_ADDR) begin
            csr_data_out = {!w_empty, 23'b0, w_head};
        end else if (csr_addr == STATUS_ADDR) begin
            csr_data_out = {16'b0, 8'(count_q), 4'b0, w_full, !w_empty,
                            overrun_q, framing_err_q};
        end
    end

    assign interrupt = interrupt_q;

endmodule
`default_nettype wire
